// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and forwarding controller for the decode -> ALU -> MEM -> WB core.
// A shadow pipeline records the destination register of every instruction that
// left decode during the last PIPE_DEPTH cycles. Decode source registers are
// compared against it to produce:
//   * forwarding selects (youngest producer wins),
//   * a one-cycle load-use stall when the producer is a load still in ALU,
//   * a FLUSH_CYCLES-long flush window after every taken jump.
// Saturating event counters expose stall and flush activity for debug.
//
// Ports
//   clk          in   rising-edge clock
//   resetIn      in   asynchronous, active-high reset
//   decValid     in   decode stage holds a real instruction
//   decRs1/2     in   source registers of the decoded instruction
//   decRd        in   destination register of the decoded instruction
//   decRegWrite  in   decoded instruction writes the register file
//   decIsLoad    in   decoded instruction is a load
//   jumpTaken    in   ALU resolved a taken jump/branch this cycle
//   stall        out  hold PC and IF_ID, insert a bubble into ALU
//   flush        out  squash IF_ID and the decoded instruction
//   fwdSel1/2    out  0 = register file, k = result of shadow entry k-1
//   stallCount   out  saturating count of stall cycles
//   flushCount   out  saturating count of flush cycles
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int  REG_ADDR_W   = 5,
  parameter int  PIPE_DEPTH   = 3,
  parameter int  FLUSH_CYCLES = 2,
  parameter int  CNT_W        = 16,
  localparam int FWD_W        = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  resetIn,
  input  logic                  decValid,
  input  logic [REG_ADDR_W-1:0] decRs1,
  input  logic [REG_ADDR_W-1:0] decRs2,
  input  logic [REG_ADDR_W-1:0] decRd,
  input  logic                  decRegWrite,
  input  logic                  decIsLoad,
  input  logic                  jumpTaken,
  output logic                  stall,
  output logic                  flush,
  output logic [FWD_W-1:0]      fwdSel1,
  output logic [FWD_W-1:0]      fwdSel2,
  output logic [CNT_W-1:0]      stallCount,
  output logic [CNT_W-1:0]      flushCount
);

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } entry_t;

  // Entry 0 = ALU, 1 = MEM, 2 = WB, ...
  entry_t shadow_q [PIPE_DEPTH];
  entry_t shadow_d [PIPE_DEPTH];

  // The load flag only matters while the load sits in ALU (entry 0); from MEM
  // onward its data is forwardable like any other result, so older entries
  // do not carry it.
  logic load0_q, load0_d;

  logic [3:0]       flush_rem_q, flush_rem_d;
  logic [CNT_W-1:0] stall_evt_q, stall_evt_d;
  logic [CNT_W-1:0] flush_evt_q, flush_evt_d;

  logic [PIPE_DEPTH-1:0] hit1, hit2;

  // An entry is a hazard source for rs when it will write rs; x0 never is.
  function automatic logic entry_hit(input entry_t e, input logic [REG_ADDR_W-1:0] rs);
    return e.valid && e.reg_write && (e.rd == rs) && (rs != '0);
  endfunction

  // Youngest matching entry wins. A load still in ALU has no result yet, so it
  // yields the register file select and the stall covers that cycle.
  function automatic logic [FWD_W-1:0] pick_src(input logic [PIPE_DEPTH-1:0] hit,
                                                input logic                  load0);
    logic [FWD_W-1:0] sel;
    sel = '0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      if (hit[k]) sel = FWD_W'(k + 1);
    end
    if (hit[0] && load0) sel = '0;
    return sel;
  endfunction

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    hit1 = '0;
    hit2 = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      hit1[k] = entry_hit(shadow_q[k], decRs1);
      hit2[k] = entry_hit(shadow_q[k], decRs2);
    end
  end

  // Flush is live on the jump cycle itself and while the window counter runs.
  assign flush = jumpTaken || (flush_rem_q != 4'd0);

  // Flush squashes the consumer anyway, so it overrides the stall.
  assign stall = decValid && !flush && load0_q && (hit1[0] || hit2[0]);

  always_comb begin
    fwdSel1 = '0;
    fwdSel2 = '0;
    if (decValid) begin
      fwdSel1 = pick_src(hit1, load0_q);
      fwdSel2 = pick_src(hit2, load0_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // Decoded instruction enters ALU only if it is neither stalled nor flushed.
    shadow_d[0].valid     = decValid && !stall && !flush;
    shadow_d[0].rd        = decRd;
    shadow_d[0].reg_write = decRegWrite;
    load0_d               = decIsLoad;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      shadow_d[k] = shadow_q[k-1];
    end

    // A jump during an active window reloads it, extending the flush.
    flush_rem_d = flush_rem_q;
    if (jumpTaken) begin
      flush_rem_d = FLUSH_RELOAD;
    end else if (flush_rem_q != 4'd0) begin
      flush_rem_d = flush_rem_q - 4'd1;
    end

    stall_evt_d = stall_evt_q;
    if (stall && (stall_evt_q != '1)) stall_evt_d = stall_evt_q + CNT_W'(1);

    flush_evt_d = flush_evt_q;
    if (flush && (flush_evt_q != '1)) flush_evt_d = flush_evt_q + CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge resetIn) begin
    if (resetIn) begin
      // NOTE: the shadow array is a handful of flops whose valid bits define
      // correctness, so it is reset like any other state, not left as memory.
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        shadow_q[k] <= '0;
      end
      load0_q     <= 1'b0;
      flush_rem_q <= 4'd0;
      stall_evt_q <= '0;
      flush_evt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values, independent of statement order.
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        shadow_q[k] <= shadow_d[k];
      end
      load0_q     <= load0_d;
      flush_rem_q <= flush_rem_d;
      stall_evt_q <= stall_evt_d;
      flush_evt_q <= flush_evt_d;
    end
  end

  assign stallCount = stall_evt_q;
  assign flushCount = flush_evt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for pipe_hazard_ctrl (PIPE_DEPTH=3, FLUSH_CYCLES=2,
// CNT_W=4 so counter saturation is reachable).
// The reference model keeps a per-cycle log of which instruction entered ALU;
// the instruction k+1 cycles back is the one in stage k. Flush is derived from
// the distance to the most recent jump.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int RW   = 5;
  localparam int D    = 3;
  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int SAT  = 15;
  localparam int LOGN = 8192;

  logic          clk;
  logic          resetIn;
  logic          decValid;
  logic [RW-1:0] decRs1, decRs2, decRd;
  logic          decRegWrite, decIsLoad, jumpTaken;
  logic          stall, flush;
  logic [1:0]    fwdSel1, fwdSel2;
  logic [CW-1:0] stallCount, flushCount;

  pipe_hazard_ctrl #(
    .REG_ADDR_W  (RW),
    .PIPE_DEPTH  (D),
    .FLUSH_CYCLES(FC),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .resetIn    (resetIn),
    .decValid   (decValid),
    .decRs1     (decRs1),
    .decRs2     (decRs2),
    .decRd      (decRd),
    .decRegWrite(decRegWrite),
    .decIsLoad  (decIsLoad),
    .jumpTaken  (jumpTaken),
    .stall      (stall),
    .flush      (flush),
    .fwdSel1    (fwdSel1),
    .fwdSel2    (fwdSel2),
    .stallCount (stallCount),
    .flushCount (flushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } acc_t;

  acc_t log_a [LOGN];
  int   t          = 0;      // current cycle index
  int   epoch      = 0;      // first cycle after the latest reset
  int   last_jump  = -1000;
  int   m_stall_cnt = 0;
  int   m_flush_cnt = 0;
  bit   e_stall, e_flush;
  int   e_sel1, e_sel2;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, t, act, exp);
    end
  endtask

  // How many stages ago (0 = ALU) the youngest writer of rs left decode; -1 if none.
  function automatic int writer_age(input int rs);
    if (rs == 0) return -1;
    for (int k = 0; k < D; k++) begin
      int c;
      c = t - 1 - k;
      if (c >= epoch && c >= 0 && log_a[c].v && log_a[c].wr && log_a[c].rd == rs) return k;
    end
    return -1;
  endfunction

  function automatic int sel_of(input int age);
    if (!decValid || age < 0) return 0;
    if (age == 0 && log_a[t-1].ld) return 0;
    return age + 1;
  endfunction

  task automatic model_eval();
    int  a1, a2;
    bit  load_use;
    a1 = writer_age(int'(decRs1));
    a2 = writer_age(int'(decRs2));
    e_flush  = jumpTaken || ((t - last_jump) < FC);
    load_use = (a1 == 0 && log_a[t-1].ld) || (a2 == 0 && log_a[t-1].ld);
    e_stall  = decValid && load_use && !e_flush;
    e_sel1   = sel_of(a1);
    e_sel2   = sel_of(a2);
  endtask

  task automatic compare();
    model_eval();
    check("stall",      stall,      e_stall);
    check("flush",      flush,      e_flush);
    check("fwdSel1",    fwdSel1,    e_sel1);
    check("fwdSel2",    fwdSel2,    e_sel2);
    check("stallCount", stallCount, m_stall_cnt);
    check("flushCount", flushCount, m_flush_cnt);
  endtask

  task automatic commit();
    log_a[t].v  = decValid && !e_stall && !e_flush;
    log_a[t].rd = int'(decRd);
    log_a[t].wr = decRegWrite;
    log_a[t].ld = decIsLoad;
    if (jumpTaken) last_jump = t;
    if (e_stall && m_stall_cnt < SAT) m_stall_cnt++;
    if (e_flush && m_flush_cnt < SAT) m_flush_cnt++;
    t++;
  endtask

  task automatic model_reset();
    epoch       = t;
    last_jump   = -1000;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Cycle helpers: drive at posedge+1, compare at negedge, commit at posedge.
  // ---------------------------------------------------------------------------
  task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                       input bit rw, input bit ld, input bit jt);
    decValid    = v;
    decRs1      = RW'(rs1);
    decRs2      = RW'(rs2);
    decRd       = RW'(rd);
    decRegWrite = rw;
    decIsLoad   = ld;
    jumpTaken   = jt;
  endtask

  task automatic half();
    #4;
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    half();
    tick();
  endtask

  task automatic rand_cycle();
    drive($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 2) == 0,
          $urandom_range(0, 19) == 0);
    half();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", t);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    resetIn = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    resetIn = 1'b0;
    model_reset();

    // Reset state.
    half();
    check("rst_stall", stall, 0);
    check("rst_flush", flush, 0);
    check("rst_sel1", fwdSel1, 0);
    check("rst_stall_cnt", stallCount, 0);
    tick();

    // Back-to-back ALU dependency: add x3 ; sub x5,x3,x4.
    drive(1, 1, 2, 3, 1, 0, 0); half(); tick();
    drive(1, 3, 4, 5, 1, 0, 0); half();
    check("alu_sel1", fwdSel1, 1);
    check("alu_sel2", fwdSel2, 0);
    check("alu_stall", stall, 0);
    tick();

    // Load-use: lw x7 ; add x8,x7,x7 (stalled once, then forwarded from MEM).
    drive(1, 0, 0, 7, 1, 1, 0); half(); tick();
    drive(1, 7, 7, 8, 1, 0, 0); half();
    check("lu_stall", stall, 1);
    tick();
    half();
    check("lu_stall_after", stall, 0);
    check("lu_sel1", fwdSel1, 2);
    check("lu_sel2", fwdSel2, 2);
    check("lu_stall_cnt", stallCount, 1);
    tick();

    // x0 destination never forwards.
    drive(1, 1, 0, 0, 1, 0, 0); half(); tick();
    drive(1, 0, 0, 1, 1, 0, 0); half();
    check("x0_sel1", fwdSel1, 0);
    check("x0_sel2", fwdSel2, 0);
    check("x0_stall", stall, 0);
    tick();

    // Single jump: flush for two cycles; instructions offered meanwhile are dropped.
    drive(1, 0, 0, 9, 1, 0, 1); half();
    check("jmp_flush0", flush, 1);
    tick();
    drive(1, 0, 0, 9, 1, 0, 0); half();
    check("jmp_flush1", flush, 1);
    tick();
    drive(1, 9, 9, 10, 1, 0, 0); half();
    check("jmp_flush2", flush, 0);
    check("jmp_flushed_sel", fwdSel1, 0);
    check("jmp_flush_cnt", flushCount, 2);
    tick();

    // Jump during the window extends it by one cycle.
    drive(0, 0, 0, 0, 0, 0, 1); half(); tick();
    drive(0, 0, 0, 0, 0, 0, 1); half(); tick();
    drive(0, 0, 0, 0, 0, 0, 0); half();
    check("ext_flush2", flush, 1);
    tick();
    half();
    check("ext_flush3", flush, 0);
    check("ext_flush_cnt", flushCount, 5);
    tick();

    // Flush overrides a simultaneous load-use.
    drive(1, 0, 0, 7, 1, 1, 0); half(); tick();
    drive(1, 7, 7, 8, 1, 0, 1); half();
    check("fvs_stall", stall, 0);
    check("fvs_flush", flush, 1);
    tick();
    idle_cycle();
    half();
    check("fvs_stall_cnt", stallCount, 1);
    check("fvs_flush_cnt", flushCount, 7);
    tick();

    // Drive stallCount into saturation.
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 7, 1, 1, 0); half(); tick();
      drive(1, 7, 6, 8, 1, 0, 0); half(); tick();
      half(); tick();
    end
    half();
    check("sat_stall_cnt", stallCount, SAT);
    tick();

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) rand_cycle();

    // Asynchronous reset in the middle of a flush with a load in flight.
    repeat (3) idle_cycle();
    drive(1, 0, 0, 7, 1, 1, 0); half(); tick();
    drive(1, 7, 7, 8, 1, 0, 1); half(); tick();
    drive(1, 7, 7, 8, 1, 0, 0);
    #1;
    check("pre_rst_flush", flush, 1);
    check("pre_rst_sel1", fwdSel1, 2);
    resetIn = 1'b1;
    #1;
    check("mid_rst_flush", flush, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_sel1", fwdSel1, 0);
    check("mid_rst_sel2", fwdSel2, 0);
    check("mid_rst_stall_cnt", stallCount, 0);
    check("mid_rst_flush_cnt", flushCount, 0);
    @(posedge clk);
    #1;
    resetIn = 1'b0;
    t++;
    model_reset();

    // Empty pipeline after release: the earlier load must not be seen.
    drive(1, 7, 7, 8, 1, 0, 0); half();
    check("post_rst_sel1", fwdSel1, 0);
    check("post_rst_flush", flush, 0);
    tick();
    for (int i = 0; i < 200; i++) rand_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
